prefetch_fetcher: RTL and testbench
===================================

Name: prefetch_fetcher

Overview:
- Parametrised successor to the single-byte fetcher: a prefetching instruction-fetch unit for the 6502-style core.
- Streams bytes from the synchronous memory into a DEPTH-byte queue.
- Assembles complete 1/2/3-byte instructions (opcode plus operands) and presents them to the decoder over a valid/ready handshake.
- Supports PC redirect (jump/branch/reset vector) with queue flush and discard of in-flight reads. Sits between mem and decoder.

Parameters:
- ADDR_WIDTH, 16, memory address and PC width.
- DATA_WIDTH, 8, byte width.
- DEPTH, 4, prefetch queue depth in bytes. Must be at least 3; elaboration fails otherwise.
- RESET_PC, 16'h0000, fetch PC loaded on reset.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- redirect  in  1  load redirect_pc, flush queue.
- redirect_pc  in  ADDR_WIDTH  new fetch address.
- mem_re  out  1  read request this cycle.
- mem_addr  out  ADDR_WIDTH  read address; valid when mem_re=1.
- mem_rdata  in  DATA_WIDTH  read data; valid exactly one cycle after mem_re.
- inst_valid  out  1  complete instruction at queue head.
- inst_ready  in  1  decoder accepts.
- inst_opcode  out  DATA_WIDTH  head byte.
- inst_op1  out  DATA_WIDTH  second byte; 0 if inst_len<2.
- inst_op2  out  DATA_WIDTH  third byte; 0 if inst_len<3.
- inst_len  out  2  instruction length, 1..3.
- inst_pc  out  ADDR_WIDTH  address of inst_opcode.
- q_count  out  $clog2(DEPTH+1)  bytes currently queued.

Behaviour:
- Reset (synchronous, clk edge with reset=1):
  - fetch_pc=RESET_PC, inst_pc=RESET_PC.
  - Queue empty; in-flight flag cleared.
  - Outputs: mem_re=0, inst_valid=0, q_count=0, inst_opcode/op1/op2=0, inst_len=1.
- Issue: mem_re=1 when !reset && !redirect && (q_count + inflight) < DEPTH.
  - mem_addr=fetch_pc; fetch_pc increments modulo 2^ADDR_WIDTH (0xFFFF wraps to 0x0000).
  - The credit check ignores same-cycle pops (conservative, fixed timing).
- Return: the byte arriving in cycle N+1 for an issue in cycle N is pushed at the end of N+1. It is visible at the queue head no earlier than N+2.
- Assembly:
  - inst_len comes from opcode_len(head byte).
  - inst_valid = (q_count >= inst_len). The output is combinational from registered queue state.
  - Outputs are held stable while inst_valid && !inst_ready; pushes only touch the tail.
- Pop: on inst_valid && inst_ready, remove inst_len bytes and advance inst_pc by inst_len (modulo). Push and pop may occur in the same cycle; q_count' = q_count + push - pop_len.
- Redirect (highest priority below reset):
  - Effects: fetch_pc=redirect_pc, inst_pc=redirect_pc, queue flushed.
  - The outstanding read is marked stale; its data is dropped in the next cycle.
  - No issue occurs in the redirect cycle; first new issue is the following cycle.
  - A handshake coinciding with redirect counts as delivered to the decoder; the flush occurs regardless.
- Length rule (cc=op[1:0], bbb=op[4:2]):
  - cc=01: bbb 011/110/111 give 3, else 2.
  - cc=10: bbb 010/110 give 1; 011/111 give 3; else 2.
  - cc=00:
    - op 0x20 gives 3.
    - op 0x00, 0x40, 0x60 give 1.
    - Other bbb=000 gives 2.
    - bbb 001/100/101 give 2; bbb 010/110 give 1; bbb 011/111 give 3.
  - cc=11 (illegal) gives 1.
- Reset asserted mid-operation: in-flight data returning after reset is discarded.

Decomposition:
- Shared package additions:
  - opcode field positions (CC, BBB, AAA).
  - length encodings LEN_1/2/3.
  - special opcodes OP_BRK, OP_JSR, OP_RTI, OP_RTS.
  - default RESET_PC.
- One sub-module, opcode_len: combinational opcode to 2-bit length, reusable by the decoder.
- Queue is a circular buffer inside prefetch_fetcher.

Test Plan:
- Mem[0x10..]=A9 04 85 02, RESET_PC=0x0010, ready=1. mem_re at cycles 0–3 addr 10–13. First inst_valid at cycle 3: opcode A9, op1 04, len 2, inst_pc 0010. Next instruction 85 02 at inst_pc 0012.
- Same image, inst_ready=0. Issues stop after 4 bytes; q_count=4; outputs held A9/04. Release ready: pop 2, q_count=2, refill resumes.
- Mem[0x20..]=4C 34 12 (JMP abs). inst_len=3, op1=34, op2=12. Then redirect to 0x1234: queue empties, stale byte dropped, next mem_addr=1234.
- RESET_PC=0xFFFE, bytes EA EA EA. mem_addr sequence FFFE, FFFF, 0000; inst_pc wraps likewise.
- Opcode sweep 0x00–0xFF through opcode_len against the reference table. Spot checks: 00→1, 20→3, A2→2, 0A→1, B9→3, F0→2.
- Reset asserted while a read is in flight: next cycle q_count=0, inst_valid=0. First issue after release is at RESET_PC.

Source files
------------

// File: rtl/prefetch_fetcher_pkg.sv
// Shared definitions for the prefetching fetch unit and the decoder:
// opcode field positions, instruction length codes and special opcodes.
package prefetch_fetcher_pkg;

  localparam int CC_LSB  = 0;
  localparam int CC_MSB  = 1;
  localparam int BBB_LSB = 2;
  localparam int BBB_MSB = 4;
  localparam int AAA_LSB = 5;
  localparam int AAA_MSB = 7;

  localparam logic [1:0] LEN_1 = 2'd1;
  localparam logic [1:0] LEN_2 = 2'd2;
  localparam logic [1:0] LEN_3 = 2'd3;

  localparam logic [7:0] OP_BRK = 8'h00;
  localparam logic [7:0] OP_JSR = 8'h20;
  localparam logic [7:0] OP_RTI = 8'h40;
  localparam logic [7:0] OP_RTS = 8'h60;

  localparam logic [15:0] DEFAULT_RESET_PC = 16'h0000;

endpackage

// File: rtl/prefetch_fetcher_opcode_len.sv
// Combinational opcode -> instruction length (1..3 bytes) for the 6502-style
// opcode map; shared between the fetcher and the decoder.
module opcode_len
  import prefetch_fetcher_pkg::*;
(
  input  logic [7:0] opcode_i,
  output logic [1:0] len_o
);

  logic [1:0] cc;
  logic [2:0] bbb;

  assign cc  = opcode_i[CC_MSB:CC_LSB];
  assign bbb = opcode_i[BBB_MSB:BBB_LSB];

  always_comb begin
    len_o = LEN_1;
    case (cc)
      2'b01: begin
        len_o = (bbb == 3'b011 || bbb == 3'b110 || bbb == 3'b111) ? LEN_3 : LEN_2;
      end
      2'b10: begin
        case (bbb)
          3'b010, 3'b110: len_o = LEN_1;
          3'b011, 3'b111: len_o = LEN_3;
          default:        len_o = LEN_2;
        endcase
      end
      2'b00: begin
        case (bbb)
          // Row 000 mixes implied stack ops with JSR absolute and immediates
          3'b000: begin
            if (opcode_i == OP_JSR) begin
              len_o = LEN_3;
            end else if (opcode_i == OP_BRK || opcode_i == OP_RTI || opcode_i == OP_RTS) begin
              len_o = LEN_1;
            end else begin
              len_o = LEN_2;
            end
          end
          3'b001, 3'b100, 3'b101: len_o = LEN_2;
          3'b010, 3'b110:         len_o = LEN_1;
          default:                len_o = LEN_3;
        endcase
      end
      default: len_o = LEN_1;
    endcase
  end

endmodule

// File: rtl/prefetch_fetcher.sv
// Prefetching instruction fetcher: streams bytes from synchronous memory into
// a circular byte queue and presents whole instructions to the decoder.
module prefetch_fetcher
  import prefetch_fetcher_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = ADDR_WIDTH'(DEFAULT_RESET_PC)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         redirect,
  input  logic [ADDR_WIDTH-1:0]        redirect_pc,
  output logic                         mem_re,
  output logic [ADDR_WIDTH-1:0]        mem_addr,
  input  logic [DATA_WIDTH-1:0]        mem_rdata,
  output logic                         inst_valid,
  input  logic                         inst_ready,
  output logic [DATA_WIDTH-1:0]        inst_opcode,
  output logic [DATA_WIDTH-1:0]        inst_op1,
  output logic [DATA_WIDTH-1:0]        inst_op2,
  output logic [1:0]                   inst_len,
  output logic [ADDR_WIDTH-1:0]        inst_pc,
  output logic [$clog2(DEPTH+1)-1:0]   q_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W:0] DEPTH_PTR = (PTR_W + 1)'(DEPTH);
  localparam logic [CNT_W:0] DEPTH_CNT = (CNT_W + 1)'(DEPTH);

  generate
    if (DEPTH < 3) begin : g_depth_check
      $error("prefetch_fetcher: DEPTH must be at least 3");
    end
  endgenerate

  logic [DATA_WIDTH-1:0] queue_q [DEPTH];
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  inflight_q, inflight_d;
  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d, inst_pc_q, inst_pc_d;

  logic [PTR_W-1:0]      rd_ptr_p1, rd_ptr_p2;
  logic [CNT_W:0]        occupancy;
  logic                  issue, pop, wr_en;

  // Pointer advance modulo DEPTH; k never exceeds DEPTH so one wrap suffices.
  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p, input logic [1:0] k);
    logic [PTR_W:0] sum;
    sum = {1'b0, p} + (PTR_W + 1)'(k);
    if (sum >= DEPTH_PTR) begin
      sum = sum - DEPTH_PTR;
    end
    return sum[PTR_W-1:0];
  endfunction

  assign rd_ptr_p1 = ptr_add(rd_ptr_q, 2'd1);
  assign rd_ptr_p2 = ptr_add(rd_ptr_q, 2'd2);

  // Empty slots read as zero so the idle outputs decode as a 1-byte opcode 0.
  assign inst_opcode = (count_q != '0) ? queue_q[rd_ptr_q] : '0;
  assign inst_op1    = (count_q >= CNT_W'(2) && inst_len != LEN_1) ? queue_q[rd_ptr_p1] : '0;
  assign inst_op2    = (count_q >= CNT_W'(3) && inst_len == LEN_3) ? queue_q[rd_ptr_p2] : '0;

  opcode_len u_opcode_len (
    .opcode_i (inst_opcode[7:0]),
    .len_o    (inst_len)
  );

  assign inst_valid = (count_q >= CNT_W'(inst_len));
  assign inst_pc    = inst_pc_q;
  assign q_count    = count_q;

  // Credit counts the outstanding read but not a same-cycle pop.
  assign occupancy = {1'b0, count_q} + (CNT_W + 1)'(inflight_q);
  assign issue     = !reset && !redirect && (occupancy < DEPTH_CNT);
  assign mem_re    = issue;
  assign mem_addr  = fetch_pc_q;
  assign pop       = inst_valid && inst_ready;
  assign wr_en     = inflight_q && !redirect && !reset;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    inst_pc_d  = inst_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    inflight_d = issue;
    if (redirect) begin
      fetch_pc_d = redirect_pc;
      inst_pc_d  = redirect_pc;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (issue) begin
        fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(1);
      end
      if (pop) begin
        inst_pc_d = inst_pc_q + ADDR_WIDTH'(inst_len);
        rd_ptr_d  = ptr_add(rd_ptr_q, inst_len);
      end
      if (wr_en) begin
        wr_ptr_d = ptr_add(wr_ptr_q, 2'd1);
      end
      count_d = count_q + CNT_W'(wr_en) - (pop ? CNT_W'(inst_len) : '0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      inst_pc_q  <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      inflight_q <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      inst_pc_q  <= inst_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      queue_q[wr_ptr_q] <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_prefetch_fetcher.sv
// Self-checking bench for prefetch_fetcher: directed sequences, an opcode
// length table/sweep, and a randomized run against an instruction-stream model.
module tb_prefetch_fetcher;

  localparam logic [15:0] RST_PC = 16'h0010;

  logic        clk;
  logic        reset, redirect, inst_ready;
  logic [15:0] redirect_pc;
  logic        mem_re, inst_valid;
  logic [15:0] mem_addr, inst_pc;
  logic [7:0]  mem_rdata, inst_opcode, inst_op1, inst_op2;
  logic [1:0]  inst_len;
  logic [2:0]  q_count;

  logic [7:0]  lut_op;
  logic [1:0]  lut_len;

  logic [7:0]  mem [0:65535];

  int checks = 0;
  int errors = 0;

  prefetch_fetcher #(
    .ADDR_WIDTH (16),
    .DATA_WIDTH (8),
    .DEPTH      (4),
    .RESET_PC   (RST_PC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .mem_re      (mem_re),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst_opcode (inst_opcode),
    .inst_op1    (inst_op1),
    .inst_op2    (inst_op2),
    .inst_len    (inst_len),
    .inst_pc     (inst_pc),
    .q_count     (q_count)
  );

  opcode_len u_lut (
    .opcode_i (lut_op),
    .len_o    (lut_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memory: data for an address presented in cycle N appears in N+1.
  always @(posedge clk) mem_rdata <= mem[mem_addr];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Length from the 6502 opcode map, organised by operand shape.
  function automatic int ref_len(input logic [7:0] op);
    logic [1:0] cc;
    logic [2:0] b;
    cc = op[1:0];
    b  = op[4:2];
    if (cc == 2'b11) return 1;
    if (cc == 2'b00 && b == 3'd0) begin
      if (op == 8'h20) return 3;
      if (op == 8'h00 || op == 8'h40 || op == 8'h60) return 1;
      return 2;
    end
    if (b == 3'd3 || b == 3'd7) return 3;
    if (cc == 2'b01) return (b == 3'd6) ? 3 : 2;
    if (b == 3'd2 || b == 3'd6) return 1;
    return 2;
  endfunction

  // Reference model: the decoder must see the byte stream starting at exp_pc,
  // and memory reads must walk sequentially from exp_fetch.
  bit          sb_en = 0;
  logic [15:0] exp_pc, exp_fetch, pc1, pc2;
  int          exp_ln, stall;

  always @(negedge clk) begin
    if (sb_en) begin
      if (reset) begin
        chk("sb_mem_re_in_reset", 32'(mem_re), 32'd0);
        exp_pc    = RST_PC;
        exp_fetch = RST_PC;
        stall     = 0;
      end else begin
        pc1    = exp_pc + 16'd1;
        pc2    = exp_pc + 16'd2;
        exp_ln = ref_len(mem[exp_pc]);
        chk("sb_inst_pc", 32'(inst_pc), 32'(exp_pc));
        chk("sb_q_count_bound", 32'(q_count <= 3'd4), 32'd1);
        chk("sb_valid_rule", 32'(inst_valid), 32'(int'(q_count) >= exp_ln));
        if (inst_valid) begin
          chk("sb_opcode", 32'(inst_opcode), 32'(mem[exp_pc]));
          chk("sb_len", 32'(inst_len), 32'(exp_ln));
          chk("sb_op1", 32'(inst_op1), (exp_ln >= 2) ? 32'(mem[pc1]) : 32'd0);
          chk("sb_op2", 32'(inst_op2), (exp_ln >= 3) ? 32'(mem[pc2]) : 32'd0);
          if (inst_ready) exp_pc = exp_pc + 16'(exp_ln);
        end
        if (mem_re) begin
          chk("sb_mem_addr", 32'(mem_addr), 32'(exp_fetch));
          exp_fetch = exp_fetch + 16'd1;
        end
        if (redirect) begin
          chk("sb_no_issue_on_redirect", 32'(mem_re), 32'd0);
          exp_pc    = redirect_pc;
          exp_fetch = redirect_pc;
          stall     = 0;
        end else if (inst_valid) begin
          stall = 0;
        end else begin
          stall++;
        end
        chk("sb_liveness", 32'(stall > 8), 32'd0);
        if (stall > 8) stall = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic chk_reset_state();
    chk("rst_mem_re", 32'(mem_re), 32'd0);
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_q_count", 32'(q_count), 32'd0);
    chk("rst_opcode", 32'(inst_opcode), 32'd0);
    chk("rst_op1", 32'(inst_op1), 32'd0);
    chk("rst_op2", 32'(inst_op2), 32'd0);
    chk("rst_len", 32'(inst_len), 32'd1);
    chk("rst_inst_pc", 32'(inst_pc), 32'(RST_PC));
  endtask

  typedef struct {
    logic [7:0] op;
    logic [1:0] len;
  } len_vec_t;

  len_vec_t    vecs [6];
  logic [15:0] t1_addr [4];
  bit          found;
  int          r;

  initial begin
    reset = 1'b1; redirect = 1'b0; redirect_pc = '0; inst_ready = 1'b0; lut_op = '0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    mem[16'h0010] = 8'hA9; mem[16'h0011] = 8'h04; mem[16'h0012] = 8'h85; mem[16'h0013] = 8'h02;
    mem[16'h0020] = 8'h4C; mem[16'h0021] = 8'h34; mem[16'h0022] = 8'h12;
    mem[16'hFFFE] = 8'hEA; mem[16'hFFFF] = 8'hEA; mem[16'h0000] = 8'hEA;
    vecs[0] = '{8'h00, 2'd1}; vecs[1] = '{8'h20, 2'd3}; vecs[2] = '{8'hA2, 2'd2};
    vecs[3] = '{8'h0A, 2'd1}; vecs[4] = '{8'hB9, 2'd3}; vecs[5] = '{8'hF0, 2'd2};
    t1_addr[0] = 16'h0010; t1_addr[1] = 16'h0011; t1_addr[2] = 16'h0012; t1_addr[3] = 16'h0013;
    sb_en = 1;

    for (int i = 0; i < 6; i++) begin
      lut_op = vecs[i].op;
      #1;
      chk($sformatf("len_spot_%02h", vecs[i].op), 32'(lut_len), 32'(vecs[i].len));
    end
    for (int i = 0; i < 256; i++) begin
      lut_op = 8'(i);
      #1;
      chk($sformatf("len_sweep_%02h", i), 32'(lut_len), 32'(ref_len(lut_op)));
    end

    // Reset state, then streaming with the decoder always ready
    step(); smp(); chk_reset_state();
    step(); reset = 1'b0; inst_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) step();
      smp();
      chk($sformatf("t1_mem_re_c%0d", c), 32'(mem_re), 32'd1);
      chk($sformatf("t1_mem_addr_c%0d", c), 32'(mem_addr), 32'(t1_addr[c]));
    end
    chk("t1_valid_c3", 32'(inst_valid), 32'd1);
    chk("t1_opcode", 32'(inst_opcode), 32'hA9);
    chk("t1_op1", 32'(inst_op1), 32'h04);
    chk("t1_len", 32'(inst_len), 32'd2);
    chk("t1_pc", 32'(inst_pc), 32'h0010);
    found = 0;
    for (int i = 0; i < 6 && !found; i++) begin
      step(); smp();
      found = inst_valid;
    end
    chk("t1_second_found", 32'(found), 32'd1);
    chk("t1_second_pc", 32'(inst_pc), 32'h0012);
    chk("t1_second_opcode", 32'(inst_opcode), 32'h85);
    chk("t1_second_op1", 32'(inst_op1), 32'h02);

    // Decoder stalled: queue fills to DEPTH and outputs hold
    step(); reset = 1'b1; inst_ready = 1'b0;
    step(); smp(); chk_reset_state();
    step(); reset = 1'b0;
    for (int c = 1; c < 8; c++) step();
    smp();
    chk("t2_q_full", 32'(q_count), 32'd4);
    chk("t2_no_issue", 32'(mem_re), 32'd0);
    chk("t2_valid", 32'(inst_valid), 32'd1);
    chk("t2_opcode", 32'(inst_opcode), 32'hA9);
    chk("t2_op1", 32'(inst_op1), 32'h04);
    chk("t2_op2", 32'(inst_op2), 32'd0);
    step(); inst_ready = 1'b1; smp();
    chk("t2_handshake", 32'(inst_valid), 32'd1);
    step(); inst_ready = 1'b0; smp();
    chk("t2_q_after_pop", 32'(q_count), 32'd2);
    chk("t2_refill", 32'(mem_re), 32'd1);
    chk("t2_refill_addr", 32'(mem_addr), 32'h0014);
    chk("t2_next_pc", 32'(inst_pc), 32'h0012);

    // JMP abs at 0x20, then redirect with coinciding handshake and a read in flight
    step(); redirect = 1'b1; redirect_pc = 16'h0020; smp();
    chk("t3_redir_no_issue", 32'(mem_re), 32'd0);
    for (int c = 0; c < 4; c++) begin
      step(); redirect = 1'b0; smp();
      chk($sformatf("t3_addr_c%0d", c), 32'(mem_addr), 32'(16'h0020 + 16'(c)));
    end
    step(); redirect = 1'b1; redirect_pc = 16'h1234; inst_ready = 1'b1; smp();
    chk("t3_valid", 32'(inst_valid), 32'd1);
    chk("t3_opcode", 32'(inst_opcode), 32'h4C);
    chk("t3_len", 32'(inst_len), 32'd3);
    chk("t3_op1", 32'(inst_op1), 32'h34);
    chk("t3_op2", 32'(inst_op2), 32'h12);
    chk("t3_pc", 32'(inst_pc), 32'h0020);
    step(); redirect = 1'b0; inst_ready = 1'b0; smp();
    chk("t3_flushed", 32'(q_count), 32'd0);
    chk("t3_flush_invalid", 32'(inst_valid), 32'd0);
    chk("t3_new_issue", 32'(mem_re), 32'd1);
    chk("t3_new_addr", 32'(mem_addr), 32'h1234);
    chk("t3_new_pc", 32'(inst_pc), 32'h1234);
    step(); smp();
    chk("t3_stale_dropped", 32'(q_count), 32'd0);

    // Address wrap at the top of memory
    step(); redirect = 1'b1; redirect_pc = 16'hFFFE; inst_ready = 1'b1; smp();
    step(); redirect = 1'b0; smp();
    chk("t4_addr0", 32'(mem_addr), 32'hFFFE);
    step(); smp();
    chk("t4_addr1", 32'(mem_addr), 32'hFFFF);
    step(); smp();
    chk("t4_addr2", 32'(mem_addr), 32'h0000);
    chk("t4_pc0_valid", 32'(inst_valid), 32'd1);
    chk("t4_pc0", 32'(inst_pc), 32'hFFFE);
    step(); smp();
    chk("t4_pc1", 32'(inst_pc), 32'hFFFF);
    step(); smp();
    chk("t4_pc2", 32'(inst_pc), 32'h0000);
    chk("t4_pc2_opcode", 32'(inst_opcode), 32'hEA);

    // Reset while a read is outstanding
    step(); redirect = 1'b1; redirect_pc = 16'h0040; inst_ready = 1'b0; smp();
    step(); redirect = 1'b0; smp();
    chk("t5_issue", 32'(mem_re), 32'd1);
    step(); reset = 1'b1; smp();
    chk("t5_no_issue_in_reset", 32'(mem_re), 32'd0);
    step(); reset = 1'b0; smp();
    chk("t5_q_empty", 32'(q_count), 32'd0);
    chk("t5_invalid", 32'(inst_valid), 32'd0);
    chk("t5_first_addr", 32'(mem_addr), 32'(RST_PC));
    step(); smp();
    chk("t5_inflight_dropped", 32'(q_count), 32'd0);

    // Randomized traffic; the reference model does the checking
    for (int c = 0; c < 3000; c++) begin
      step();
      r           = $urandom_range(0, 999);
      reset       = (r < 5);
      redirect    = (r >= 5 && r < 35);
      redirect_pc = (r % 2 == 0) ? 16'($urandom) : 16'hFFFC + 16'(r % 4);
      inst_ready  = ($urandom_range(0, 9) < 7);
      smp();
    end
    step(); reset = 1'b0; redirect = 1'b0; smp();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
